id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register stage sitting directly downstream of the register file.
- Captures decoded instruction fields and the rs/rd operand values read asynchronously from the register file, applying EX- and MEM-stage forwarding.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and flush.
- Register file writes on negedge, so WB results are already visible in the same cycle; no WB forwarding path.

---
 rtl/id_ex_operand_stage.sv | 116 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// id_ex_operand_stage : ID/EX register with EX/MEM operand forwarding and
//                       load-use bubble insertion.            Revision: 1.0
// ============================================================================
module id_ex_operand_stage #(
  parameter int addr_width_p = 6,
  parameter int op_width_p   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    id_valid_i,
  input  logic [op_width_p-1:0]   id_op_i,
  input  logic [addr_width_p-1:0] id_rs_addr_i,
  input  logic [addr_width_p-1:0] id_rd_addr_i,
  input  logic                    id_rs_used_i,
  input  logic                    id_rd_used_i,
  input  logic                    id_wen_i,
  input  logic                    id_is_load_i,
  input  logic [31:0]             rf_rs_val_i,
  input  logic [31:0]             rf_rd_val_i,
  input  logic [31:0]             ex_result_i,
  input  logic                    mem_wen_i,
  input  logic [addr_width_p-1:0] mem_addr_i,
  input  logic [31:0]             mem_data_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    ex_valid_o,
  output logic [op_width_p-1:0]   ex_op_o,
  output logic [31:0]             ex_rs_val_o,
  output logic [31:0]             ex_rd_val_o,
  output logic [addr_width_p-1:0] ex_waddr_o,
  output logic                    ex_wen_o,
  output logic                    ex_is_load_o
);

  logic                    r_valid;
  logic [op_width_p-1:0]   r_op;
  logic [31:0]             r_rs_val;
  logic [31:0]             r_rd_val;
  logic [addr_width_p-1:0] r_waddr;
  logic                    r_wen;
  logic                    r_is_load;

  logic                    w_ex_fwd_ok;
  logic                    w_ex_load;
  logic                    w_rs_hit_ex;
  logic                    w_rd_hit_ex;
  logic                    w_rs_hit_mem;
  logic                    w_rd_hit_mem;
  logic [31:0]             w_rs_val;
  logic [31:0]             w_rd_val;
  logic                    w_load_use;

  // A load in EX has no result yet; it can only be consumed after a bubble.
  assign w_ex_fwd_ok  = r_valid & r_wen & ~r_is_load;
  assign w_ex_load    = r_valid & r_wen & r_is_load;

  assign w_rs_hit_ex  = w_ex_fwd_ok & (r_waddr == id_rs_addr_i);
  assign w_rd_hit_ex  = w_ex_fwd_ok & (r_waddr == id_rd_addr_i);
  assign w_rs_hit_mem = mem_wen_i & (mem_addr_i == id_rs_addr_i);
  assign w_rd_hit_mem = mem_wen_i & (mem_addr_i == id_rd_addr_i);

  always_comb begin
    w_rs_val = rf_rs_val_i;
    if (w_rs_hit_ex)       w_rs_val = ex_result_i;
    else if (w_rs_hit_mem) w_rs_val = mem_data_i;
  end

  always_comb begin
    w_rd_val = rf_rd_val_i;
    if (w_rd_hit_ex)       w_rd_val = ex_result_i;
    else if (w_rd_hit_mem) w_rd_val = mem_data_i;
  end

  assign w_load_use = w_ex_load & id_valid_i &
                      ((id_rs_used_i & (r_waddr == id_rs_addr_i)) |
                       (id_rd_used_i & (r_waddr == id_rd_addr_i)));

  assign stall_o = (w_load_use | stall_i) & ~flush_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_rs_val  <= '0;
      r_rd_val  <= '0;
      r_waddr   <= '0;
      r_wen     <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush_i || (!stall_i && w_load_use)) begin
      r_valid   <= 1'b0;
      r_wen     <= 1'b0;
      r_is_load <= 1'b0;
    end else if (!stall_i) begin
      r_valid   <= id_valid_i;
      r_op      <= id_op_i;
      r_rs_val  <= w_rs_val;
      r_rd_val  <= w_rd_val;
      r_waddr   <= id_rd_addr_i;
      r_wen     <= id_wen_i & id_valid_i;
      r_is_load <= id_is_load_i & id_valid_i;
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_op_o      = r_op;
  assign ex_rs_val_o  = r_rs_val;
  assign ex_rd_val_o  = r_rd_val;
  assign ex_waddr_o   = r_waddr;
  assign ex_wen_o     = r_wen;
  assign ex_is_load_o = r_is_load;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_operand_stage : directed bench for the ID/EX operand stage.
// Revision: 1.0
// ============================================================================
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid_i;
  logic [7:0]  id_op_i;
  logic [5:0]  id_rs_addr_i;
  logic [5:0]  id_rd_addr_i;
  logic        id_rs_used_i;
  logic        id_rd_used_i;
  logic        id_wen_i;
  logic        id_is_load_i;
  logic [31:0] rf_rs_val_i;
  logic [31:0] rf_rd_val_i;
  logic [31:0] ex_result_i;
  logic        mem_wen_i;
  logic [5:0]  mem_addr_i;
  logic [31:0] mem_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        ex_valid_o;
  logic [7:0]  ex_op_o;
  logic [31:0] ex_rs_val_o;
  logic [31:0] ex_rd_val_o;
  logic [5:0]  ex_waddr_o;
  logic        ex_wen_o;
  logic        ex_is_load_o;

  int total = 0;
  int bad   = 0;

  id_ex_operand_stage #(.addr_width_p(6), .op_width_p(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid_i(id_valid_i), .id_op_i(id_op_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs_used_i(id_rs_used_i), .id_rd_used_i(id_rd_used_i),
    .id_wen_i(id_wen_i), .id_is_load_i(id_is_load_i),
    .rf_rs_val_i(rf_rs_val_i), .rf_rd_val_i(rf_rd_val_i),
    .ex_result_i(ex_result_i),
    .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o),
    .ex_rs_val_o(ex_rs_val_o), .ex_rd_val_o(ex_rd_val_o),
    .ex_waddr_o(ex_waddr_o), .ex_wen_o(ex_wen_o), .ex_is_load_o(ex_is_load_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 0; id_op_i = '0; id_rs_addr_i = '0; id_rd_addr_i = '0;
    id_rs_used_i = 0; id_rd_used_i = 0; id_wen_i = 0; id_is_load_i = 0;
    rf_rs_val_i = '0; rf_rd_val_i = '0; ex_result_i = '0;
    mem_wen_i = 0; mem_addr_i = '0; mem_data_i = '0;
    stall_i = 0; flush_i = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [5:0] rs, input logic [5:0] rd,
                       input logic rs_used, input logic rd_used,
                       input logic wen, input logic ld);
    id_valid_i = 1; id_op_i = op; id_rs_addr_i = rs; id_rd_addr_i = rd;
    id_rs_used_i = rs_used; id_rd_used_i = rd_used; id_wen_i = wen; id_is_load_i = ld;
  endtask

  initial begin
    idle();
    reset_n = 0;
    #12;
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_rs",    ex_rs_val_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    reset_n = 1;
    @(negedge clk);

    // Plain capture, register-file operands
    issue(8'h11, 6'd2, 6'd5, 1, 0, 1, 0);
    rf_rs_val_i = 32'h10; rf_rd_val_i = 32'h20;
    tick();
    chk("cap_valid", 32'(ex_valid_o), 32'd1);
    chk("cap_waddr", 32'(ex_waddr_o), 32'd5);
    chk("cap_op",    32'(ex_op_o), 32'h11);
    chk("cap_rs",    ex_rs_val_o, 32'h10);
    chk("cap_wen",   32'(ex_wen_o), 32'd1);

    // EX forward onto rs
    issue(8'h22, 6'd5, 6'd9, 1, 0, 0, 0);
    rf_rs_val_i = 32'hDEAD; rf_rd_val_i = 32'h99; ex_result_i = 32'h1234;
    tick();
    chk("exfwd_rs",  ex_rs_val_o, 32'h1234);
    chk("exfwd_rd",  ex_rd_val_o, 32'h99);
    chk("exfwd_wen", 32'(ex_wen_o), 32'd0);

    // EX beats MEM on rd
    issue(8'h33, 6'd1, 6'd3, 0, 0, 1, 0);
    tick();
    issue(8'h34, 6'd4, 6'd3, 1, 1, 0, 0);
    rf_rs_val_i = 32'h44; rf_rd_val_i = 32'hCCCC; ex_result_i = 32'hAAAA;
    mem_wen_i = 1; mem_addr_i = 6'd3; mem_data_i = 32'hBBBB;
    tick();
    chk("prio_ex_rd", ex_rd_val_o, 32'hAAAA);
    chk("prio_ex_rs", ex_rs_val_o, 32'h44);

    // Invalid EX writer -> MEM wins
    issue(8'h35, 6'd1, 6'd3, 0, 0, 1, 0);
    id_valid_i = 0;
    tick();
    chk("inv_valid", 32'(ex_valid_o), 32'd0);
    chk("inv_wen",   32'(ex_wen_o), 32'd0);
    issue(8'h36, 6'd4, 6'd3, 1, 1, 0, 0);
    tick();
    chk("prio_mem_rd", ex_rd_val_o, 32'hBBBB);

    // Address 0 forwarded from MEM like any other register
    issue(8'h37, 6'd0, 6'd2, 1, 0, 0, 0);
    mem_addr_i = 6'd0; mem_data_i = 32'h77; rf_rs_val_i = 32'h1;
    tick();
    chk("r0_fwd", ex_rs_val_o, 32'h77);

    // Load-use hazard
    idle();
    issue(8'h40, 6'd1, 6'd7, 0, 0, 1, 1);
    tick();
    chk("ld_isload", 32'(ex_is_load_o), 32'd1);
    issue(8'h41, 6'd7, 6'd8, 1, 0, 1, 0);
    rf_rs_val_i = 32'h0BAD; ex_result_i = 32'hEEEE;
    #1;
    chk("lu_stall", 32'(stall_o), 32'd1);
    id_rs_used_i = 0;
    #1;
    chk("lu_unused", 32'(stall_o), 32'd0);
    id_rs_used_i = 1; id_valid_i = 0;
    #1;
    chk("lu_invalid", 32'(stall_o), 32'd0);
    id_valid_i = 1;
    tick();
    chk("bub_valid",  32'(ex_valid_o), 32'd0);
    chk("bub_wen",    32'(ex_wen_o), 32'd0);
    chk("bub_isload", 32'(ex_is_load_o), 32'd0);
    chk("bub_stall",  32'(stall_o), 32'd0);
    mem_wen_i = 1; mem_addr_i = 6'd7; mem_data_i = 32'h55;
    tick();
    chk("lu_rs",    ex_rs_val_o, 32'h55);
    chk("lu_valid", 32'(ex_valid_o), 32'd1);
    chk("lu_waddr", 32'(ex_waddr_o), 32'd8);

    // Downstream stall holds EX for three cycles
    idle();
    issue(8'h50, 6'd9, 6'd10, 1, 1, 0, 1);
    rf_rs_val_i = 32'h9999; stall_i = 1;
    #1;
    chk("st_stallo", 32'(stall_o), 32'd1);
    tick(); tick(); tick();
    chk("st_valid", 32'(ex_valid_o), 32'd1);
    chk("st_waddr", 32'(ex_waddr_o), 32'd8);
    chk("st_rs",    ex_rs_val_o, 32'h55);
    chk("st_op",    32'(ex_op_o), 32'h41);
    chk("st_wen",   32'(ex_wen_o), 32'd1);

    // Flush overrides a load-use hazard
    idle();
    issue(8'h60, 6'd1, 6'd7, 0, 0, 1, 1);
    tick();
    issue(8'h61, 6'd7, 6'd2, 1, 0, 1, 0);
    flush_i = 1;
    #1;
    chk("fl_stallo", 32'(stall_o), 32'd0);
    tick();
    chk("fl_valid",  32'(ex_valid_o), 32'd0);
    chk("fl_isload", 32'(ex_is_load_o), 32'd0);

    // Asynchronous reset mid-operation
    idle();
    issue(8'h70, 6'd3, 6'd4, 0, 0, 1, 0);
    rf_rs_val_i = 32'h123;
    tick();
    chk("pre_rst_valid", 32'(ex_valid_o), 32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("arst_valid", 32'(ex_valid_o), 32'd0);
    chk("arst_rs",    ex_rs_val_o, 32'd0);
    chk("arst_op",    32'(ex_op_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    reset_n = 1;
    issue(8'h71, 6'd3, 6'd6, 0, 0, 1, 0);
    rf_rs_val_i = 32'h321;
    tick();
    chk("post_rst_valid", 32'(ex_valid_o), 32'd1);
    chk("post_rst_rs",    ex_rs_val_o, 32'h321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
